// File: rtl/ddr_deserializer_align_if.sv
// Lane-side and word-side signal bundle for the DDR deserializer/aligner.
// The master drives the lane and control inputs; the slave produces the assembled word.
interface ddr_deserializer_align_if #(
  parameter int D = 8,
  parameter int S = 8
) ();
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  logic           in_valid;
  logic [D-1:0]   data_in;
  logic           bitslip;
  logic           train_en;
  logic [D*S-1:0] data_out;
  logic           out_valid;
  logic           locked;
  logic [CW-1:0]  slip_count;

  modport master (
    output in_valid, data_in, bitslip, train_en,
    input  data_out, out_valid, locked, slip_count
  );

  modport slave (
    input  in_valid, data_in, bitslip, train_en,
    output data_out, out_valid, locked, slip_count
  );
endinterface

// File: rtl/ddr_deserializer_align.sv
// Gathers S beats of D bits into one word, with a beat-dropping slip for frame
// alignment driven either manually or by a training-word hunting FSM.
module ddr_deserializer_align #(
  parameter int             D          = 8,
  parameter int             S          = 8,
  parameter int             MSB_FIRST  = 0,
  parameter logic [D*S-1:0] PATTERN    = 64'h0706050403020100,
  parameter int             LOCK_COUNT = 4
) (
  input logic                   high_speed_clock,
  input logic                   reset,
  ddr_deserializer_align_if.slave lane
);
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(S - 1);
  localparam logic [MW-1:0] LOCK_TGT  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  slip_cnt_q, slip_cnt_d;
  logic [MW-1:0]  match_q, match_d;
  logic           pend_q, pend_d;
  logic           locked_q, locked_d;
  logic           train_prev_q, train_prev_d;
  logic           out_valid_q, out_valid_d;
  logic [D*S-1:0] data_out_q, data_out_d;
  logic [D*S-1:0] stage_q, stage_d;

  logic          manual_req, slip_now, accept, drop, word_done, fsm_slip;
  logic [CW-1:0] slot;

  always_comb begin
    manual_req = ~lane.train_en & lane.bitslip;
    // A request in the same cycle as a beat already consumes that beat.
    slip_now   = pend_q | manual_req;
    accept     = lane.in_valid & ~slip_now;
    drop       = lane.in_valid & slip_now;
    word_done  = accept & (cnt_q == LAST_BEAT);
    slot       = (MSB_FIRST != 0) ? (LAST_BEAT - cnt_q) : cnt_q;

    stage_d = stage_q;
    if (accept) stage_d[int'(slot)*D +: D] = lane.data_in;

    cnt_d = cnt_q;
    if (accept) cnt_d = word_done ? '0 : cnt_q + 1'b1;

    slip_cnt_d = slip_cnt_q;
    if (drop) slip_cnt_d = (slip_cnt_q == LAST_BEAT) ? '0 : slip_cnt_q + 1'b1;

    data_out_d   = word_done ? stage_d : data_out_q;
    out_valid_d  = word_done;
    train_prev_d = lane.train_en;
  end

  // Training FSM judges the word as it completes so lock lines up with out_valid.
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    locked_d = locked_q;
    fsm_slip = 1'b0;
    if (!lane.train_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!train_prev_q) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            match_d  = '0;
          end
        end
        HUNT: begin
          if (word_done) begin
            if (stage_d == PATTERN) begin
              match_d = match_q + 1'b1;
              if (match_d == LOCK_TGT) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              match_d  = '0;
              fsm_slip = 1'b1;
            end
          end
        end
        LOCKED:  ;
        default: state_d = IDLE;
      endcase
    end
    pend_d = drop ? 1'b0 : (slip_now | fsm_slip);
  end

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      slip_cnt_q   <= '0;
      match_q      <= '0;
      pend_q       <= 1'b0;
      locked_q     <= 1'b0;
      train_prev_q <= 1'b0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      match_q      <= match_d;
      pend_q       <= pend_d;
      locked_q     <= locked_d;
      train_prev_q <= train_prev_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  // Staging slots are fully rewritten every frame, so they need no reset.
  always_ff @(posedge high_speed_clock) begin
    stage_q <= stage_d;
  end

  assign lane.data_out   = data_out_q;
  assign lane.out_valid  = out_valid_q;
  assign lane.locked     = locked_q;
  assign lane.slip_count = slip_cnt_q;
endmodule

// File: tb/tb_ddr_deserializer_align.sv
// Bench for ddr_deserializer_align: LSB-first (trainable) and MSB-first (manual)
// instances driven by directed and random lane traffic against a beat-list model.
module tb_ddr_deserializer_align;
  localparam int D  = 8;
  localparam int S  = 4;
  localparam int LC = 2;
  localparam logic [31:0] PAT = 32'h03020100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic       bs  = 1'b0;
  logic       te  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rst_want = 1'b1;
  logic       te_want  = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ddr_deserializer_align_if #(.D(D), .S(S)) if0 ();
  ddr_deserializer_align_if #(.D(D), .S(S)) if1 ();

  assign if0.in_valid = vld;
  assign if0.data_in  = din;
  assign if0.bitslip  = bs;
  assign if0.train_en = te;
  assign if1.in_valid = vld;
  assign if1.data_in  = din;
  assign if1.bitslip  = bs;
  assign if1.train_en = 1'b0;

  ddr_deserializer_align #(.D(D), .S(S), .MSB_FIRST(0), .PATTERN(PAT), .LOCK_COUNT(LC)) dut0 (
    .high_speed_clock(clk), .reset(rst), .lane(if0.slave));
  ddr_deserializer_align #(.D(D), .S(S), .MSB_FIRST(1), .PATTERN(PAT), .LOCK_COUNT(LC)) dut1 (
    .high_speed_clock(clk), .reset(rst), .lane(if1.slave));

  // Reference model: list of collected beats per instance; mode 0=idle 1=hunt 2=locked.
  logic [7:0]  m_beats [2][S];
  int          m_n     [2];
  bit          m_pend  [2];
  int          m_slips [2];
  int          m_mode  [2];
  int          m_match [2];
  bit          m_locked[2];
  bit          m_prev  [2];
  bit          m_ov    [2];
  logic [31:0] m_dout  [2];

  task automatic model_step(input int i);
    bit          te_i, req;
    logic [31:0] w;
    te_i = (i == 0) ? te : 1'b0;
    if (rst) begin
      m_n[i] = 0; m_pend[i] = 0; m_slips[i] = 0; m_mode[i] = 0; m_match[i] = 0;
      m_locked[i] = 0; m_prev[i] = 0; m_ov[i] = 0; m_dout[i] = '0;
      return;
    end
    m_ov[i] = 0;
    req = !te_i && bs;
    if (vld) begin
      if (m_pend[i] || req) begin
        m_pend[i]  = 0;
        m_slips[i] = (m_slips[i] + 1) % S;
      end else begin
        m_beats[i][m_n[i]] = din;
        m_n[i]++;
        if (m_n[i] == S) begin
          w = '0;
          for (int k = 0; k < S; k++)
            w = w | (32'(m_beats[i][k]) << (D * ((i == 1) ? (S - 1 - k) : k)));
          m_dout[i] = w;
          m_ov[i]   = 1;
          m_n[i]    = 0;
          if (te_i && m_mode[i] == 1) begin
            if (w == PAT) begin
              m_match[i]++;
              if (m_match[i] == LC) begin
                m_mode[i]   = 2;
                m_locked[i] = 1;
              end
            end else begin
              m_match[i] = 0;
              m_pend[i]  = 1;
            end
          end
        end
      end
    end else if (req) begin
      m_pend[i] = 1;
    end
    if (!te_i) m_mode[i] = 0;
    else if (!m_prev[i]) begin
      m_mode[i] = 1; m_locked[i] = 0; m_match[i] = 0;
    end
    m_prev[i] = te_i;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ov0",    64'(if0.out_valid),  64'(m_ov[0]));
    chk("dout0",  64'(if0.data_out),   64'(m_dout[0]));
    chk("lock0",  64'(if0.locked),     64'(m_locked[0]));
    chk("slip0",  64'(if0.slip_count), 64'(m_slips[0]));
    chk("ov1",    64'(if1.out_valid),  64'(m_ov[1]));
    chk("dout1",  64'(if1.data_out),   64'(m_dout[1]));
    chk("lock1",  64'(if1.locked),     64'(m_locked[1]));
    chk("slip1",  64'(if1.slip_count), 64'(m_slips[1]));
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic b);
    @(negedge clk);
    check_all();
    rst = rst_want;
    te  = te_want;
    vld = v;
    din = d;
    bs  = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int ph;
    // Reset and basic assembly
    idle(3);
    rst_want = 1'b0;
    idle(1);
    chk("rst_dout", 64'(if0.data_out), 64'h0);
    chk("rst_slip", 64'(if0.slip_count), 64'h0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(k), 1'b0);
    idle(3);
    chk("t1_word0", 64'(if0.data_out), 64'h07060504);
    chk("t1_word1", 64'(if1.data_out), 64'h04050607);

    // Order and stalls
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    idle(3);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    idle(3);
    chk("t2_msb", 64'(if1.data_out), 64'h00010203);
    chk("t2_lsb", 64'(if0.data_out), 64'h03020100);

    // Manual bitslip, then a second request while one is already pending
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    idle(2);
    chk("t3_word", 64'(if0.data_out), 64'h00030201);
    chk("t3_slip1", 64'(if0.slip_count), 64'h1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h01, 1'b0);
    idle(2);
    chk("t3_slip2", 64'(if0.slip_count), 64'h2);

    // Automatic training on a stream offset by one beat
    rst_want = 1'b1;
    idle(2);
    rst_want = 1'b0;
    te_want  = 1'b1;
    idle(2);
    for (int k = 0; k < 23; k++) cyc(1'b1, 8'((1 + k) % 4), 1'b0);
    idle(1);
    chk("t4_locked", 64'(if0.locked), 64'h1);
    chk("t4_slips", 64'(if0.slip_count), 64'h3);
    chk("t4_word", 64'(if0.data_out), 64'h03020100);

    // Lock retention across garbage and train_en drop; relock on new edge
    cyc(1'b1, 8'hEF, 1'b0);
    cyc(1'b1, 8'hBE, 1'b0);
    cyc(1'b1, 8'hAD, 1'b0);
    cyc(1'b1, 8'hDE, 1'b0);
    idle(2);
    chk("t5_garbage", 64'(if0.data_out), 64'hDEADBEEF);
    chk("t5_locked", 64'(if0.locked), 64'h1);
    chk("t5_slips", 64'(if0.slip_count), 64'h3);
    te_want = 1'b0;
    idle(2);
    chk("t5_hold", 64'(if0.locked), 64'h1);
    te_want = 1'b1;
    idle(2);
    chk("t5_relearn", 64'(if0.locked), 64'h0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(k % 4), 1'b0);
    idle(1);
    chk("t5_relock", 64'(if0.locked), 64'h1);

    // Random traffic: gaps, slips, training toggles, mostly in-phase data
    ph = 0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 63) == 0) te_want = ~te_want;
      if ($urandom_range(0, 1) == 0) begin
        cyc(1'b1, 8'(ph), ($urandom_range(0, 7) == 0));
        ph = (ph + 1) % 4;
      end else begin
        cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0));
      end
    end
    te_want = 1'b0;
    idle(2);

    // Reset mid-frame with a slip pending
    rst_want = 1'b1;
    idle(1);
    rst_want = 1'b0;
    idle(1);
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    rst_want = 1'b1;
    idle(1);
    rst_want = 1'b0;
    idle(2);
    chk("t6_dout", 64'(if0.data_out), 64'h0);
    chk("t6_slip", 64'(if0.slip_count), 64'h0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h10 + k), 1'b0);
    idle(1);
    chk("t6_ov", 64'(if0.out_valid), 64'h1);
    chk("t6_word", 64'(if0.data_out), 64'h13121110);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
